i2s_master_tx: RTL
==================

Name: i2s_master_tx

Overview:
- I2S bus master and transmitter: derives BCLK and LRCLK from the system clock and serializes stereo samples to a codec running in slave mode.
- Counterpart of the slave-mode I2S receive path; lets the design drive the codec DAC without codec-generated clocks.
- Samples enter via a valid/ready handshake into a 2-entry frame FIFO; one stereo frame is consumed per LRCLK period.

Parameters:
- BITSIZE, 16: sample width per channel; must be 1..SLOT_BITS-1.
- SLOT_BITS, 32: BCLK periods per channel slot; a frame is 2*SLOT_BITS.
- BCLK_DIV, 16: clk cycles per BCLK period; even, >=4. 49.152 MHz / 16 = 3.072 MHz BCLK, 48 kHz LRCLK.

Ports:
- clk  in  1  system clock (49.152 MHz)
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  frame offered
- in_ready  out  1  FIFO can accept; equals !full
- left_in  in  BITSIZE  left sample, two's complement
- right_in  in  BITSIZE  right sample
- bclk  out  1  bit clock, registered
- lrclk  out  1  0 = left slot, 1 = right slot, registered
- sdata  out  1  serial data, registered
- frame_start  out  1  one-cycle pulse at each frame load
- underflow  out  1  one-cycle pulse when a frame load finds the FIFO empty

Behaviour:
- Reset values:
  - div_cnt=0, bit_cnt=2*SLOT_BITS-1.
  - bclk=0, lrclk=1, sdata=0, frame_start=0, underflow=0.
  - FIFO empty, in_ready=1, frame registers=0.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - At div_cnt==BCLK_DIV/2-1: bclk<=1 (rise).
  - At div_cnt==BCLK_DIV-1 ("tick"): bclk<=0 (fall).
- On each tick, all of the following update on the same clk edge as the BCLK fall:
  - bit_cnt<=bit_cnt+1, wrapping 2*SLOT_BITS-1 -> 0.
  - lrclk <= (new bit_cnt >= SLOT_BITS).
  - sdata updates per the data format below.
- Data format (Philips I2S):
  - Let k = new bit_cnt mod SLOT_BITS.
  - For 1<=k<=BITSIZE: sdata = bit (BITSIZE-k) of the active channel word, so the MSB appears one BCLK after the LRCLK edge.
  - Otherwise sdata=0.
  - Left word is used while lrclk=0, right word while lrclk=1.
- Frame load, on the tick where bit_cnt wraps to 0:
  - FIFO non-empty: head copied to frame registers, FIFO popped, frame_start=1 for one cycle.
  - FIFO empty: frame registers <= 0 (see optional feature), frame_start=1, underflow=1 for one cycle.
- First load after reset occurs on the first tick, i.e. lrclk falls on clk edge BCLK_DIV after reset release.
- FIFO:
  - Depth 2; push when in_valid && in_ready.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Push into an empty FIFO in the same cycle as a load is not bypassed: underflow fires and the pushed frame is used next frame.
  - in_ready deasserts the cycle after the FIFO becomes full and reasserts the cycle after a pop.
  - Inputs are sampled only at push; later changes have no effect.
- Latency: a frame pushed into an empty FIFO appears on sdata starting at the next frame boundary; its left MSB is on sdata at the tick after the load tick.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); the FIFO is flushed; the partial frame is lost.

Optional Feature:
- Macro: I2S_MASTER_TX_HOLD_EN.
- Defined: on underflow the frame registers keep the previous frame, so the last frame repeats; underflow still pulses.
- Undefined: on underflow the frame registers load 0 (silence).

Test Plan:
- Reset then idle, BITSIZE=16/SLOT_BITS=32/BCLK_DIV=16 -> bclk period 16 clk, 50% duty; lrclk period 1024 clk; first lrclk fall at edge 16; underflow pulses every 1024 clk; sdata stays 0.
- Push L=16'hA5C3, R=16'h8001 before the first load -> left slot k=1..16 shifts 1010010111000011, k=17..31 and k=0 are 0; right slot shifts 1000000000000001; frame_start coincides with the lrclk fall.
- Push 3 frames back-to-back with in_valid held high -> in_ready low after 2 accepts; the third is accepted after the first load; frames are emitted in order with no underflow.
- Push in the same cycle as a load with the FIFO empty -> underflow=1, the current frame is silent (or repeats with I2S_MASTER_TX_HOLD_EN), the pushed frame is emitted next frame.
- Assert rst_n low mid right slot -> bclk=0, lrclk=1, sdata=0 asynchronously; after release, timing restarts exactly as in the first scenario.
- Hold feature: emit L=16'h7FFF, then starve -> with the macro defined the next frame repeats 16'h7FFF; without it the next frame is 0.

Source files
------------

// File: rtl/i2s_master_tx_if.sv
// Frame handshake between an audio source and the I2S master transmitter.
interface i2s_master_tx_if #(
   parameter int unsigned BITSIZE = 16
);
   logic               in_valid;
   logic               in_ready;
   logic [BITSIZE-1:0] left_in;
   logic [BITSIZE-1:0] right_in;

   modport master (output in_valid, left_in, right_in, input in_ready);
   modport slave  (input in_valid, left_in, right_in, output in_ready);
endinterface

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: generates BCLK/LRCLK and shifts Philips-format stereo frames from a 2-deep FIFO.
// Define I2S_MASTER_TX_HOLD_EN to repeat the last frame on underflow instead of sending silence.
module i2s_master_tx #(
   parameter int unsigned BITSIZE   = 16,
   parameter int unsigned SLOT_BITS = 32,
   parameter int unsigned BCLK_DIV  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   i2s_master_tx_if.slave  bus,
   output logic            bclk,
   output logic            lrclk,
   output logic            sdata,
   output logic            frame_start,
   output logic            underflow
);
   localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
   localparam int unsigned DIV_W      = $clog2(BCLK_DIV);
   localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
   localparam int unsigned IDX_W      = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;
   localparam int unsigned WORD_W     = 2 * BITSIZE;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(BCLK_DIV / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_BITS);
   localparam logic [BIT_W-1:0] K_LAST   = BIT_W'(BITSIZE);

   logic [DIV_W-1:0]   div_cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic [BIT_W-1:0]   bit_nxt_c;
   logic [BIT_W-1:0]   slot_k_c;
   logic [IDX_W-1:0]   idx_c;
   logic               tick_c;
   logic               load_c;
   logic               lr_nxt_c;
   logic               sd_nxt_c;
   logic               push_c;
   logic               pop_c;
   logic [1:0]         count_nxt_c;

   logic [WORD_W-1:0]  fifo_mem [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         count;
   logic               in_ready_q;
   logic [BITSIZE-1:0] left_q;
   logic [BITSIZE-1:0] right_q;

   assign bus.in_ready = in_ready_q;

   // Next bit position, slot-relative index and the bit to present after the coming BCLK fall.
   always_comb begin
      tick_c    = (div_cnt == DIV_LAST);
      bit_nxt_c = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
      lr_nxt_c  = (bit_nxt_c >= SLOT_B);
      slot_k_c  = lr_nxt_c ? bit_nxt_c - SLOT_B : bit_nxt_c;
      load_c    = tick_c && (bit_nxt_c == '0);
      idx_c     = IDX_W'(K_LAST - slot_k_c);
      sd_nxt_c  = 1'b0;
      if ((slot_k_c != '0) && (slot_k_c <= K_LAST)) begin
         sd_nxt_c = lr_nxt_c ? right_q[idx_c] : left_q[idx_c];
      end
      push_c      = bus.in_valid && in_ready_q;
      pop_c       = load_c && (count != 2'd0);
      count_nxt_c = count + {1'b0, push_c} - {1'b0, pop_c};
   end

   // Clock divider and serial output timing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt     <= '0;
         bit_cnt     <= BIT_LAST;
         bclk        <= 1'b0;
         lrclk       <= 1'b1;
         sdata       <= 1'b0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         div_cnt     <= tick_c ? '0 : div_cnt + DIV_W'(1);
         frame_start <= load_c;
         underflow   <= load_c && (count == 2'd0);
         if (div_cnt == DIV_RISE) begin
            bclk <= 1'b1;
         end
         if (tick_c) begin
            bclk    <= 1'b0;
            bit_cnt <= bit_nxt_c;
            lrclk   <= lr_nxt_c;
            sdata   <= sd_nxt_c;
         end
      end
   end

   // Two-entry frame FIFO; a same-cycle push into an empty FIFO is not bypassed to the load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
         in_ready_q  <= 1'b1;
      end else begin
         if (push_c) begin
            fifo_mem[wr_ptr] <= {bus.left_in, bus.right_in};
            wr_ptr           <= ~wr_ptr;
         end
         if (pop_c) begin
            rd_ptr <= ~rd_ptr;
         end
         count      <= count_nxt_c;
         in_ready_q <= (count_nxt_c != 2'd2);
      end
   end

   // Frame registers hold the words being shifted during the current LRCLK period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left_q  <= '0;
         right_q <= '0;
      end else if (load_c) begin
         if (count != 2'd0) begin
            {left_q, right_q} <= fifo_mem[rd_ptr];
         end else begin
`ifdef I2S_MASTER_TX_HOLD_EN
            left_q  <= left_q;
            right_q <= right_q;
`else
            left_q  <= '0;
            right_q <= '0;
`endif
         end
      end
   end
endmodule
